// File: rtl/counter_ctrl_if.sv
// Control bundle between the board controls, the counter datapath and the sequencer.
// master = environment (buttons, switches, counter feedback); slave = sequencer.
interface counter_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             stop;
    logic             pause;
    logic             dir_sel;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] cnt_val;
    logic             cnt_load;
    logic [WIDTH-1:0] cnt_load_val;
    logic             cnt_en;
    logic             cnt_up;
    logic             busy;
    logic             done;

    modport master (
        output start, stop, pause, dir_sel, limit, cnt_val,
        input  cnt_load, cnt_load_val, cnt_en, cnt_up, busy, done
    );

    modport slave (
        input  start, stop, pause, dir_sel, limit, cnt_val,
        output cnt_load, cnt_load_val, cnt_en, cnt_up, busy, done
    );
endinterface

// File: rtl/counter_ctrl.sv
// Up/down counter sequencer: load start value, then prescaled count steps until terminal value.
// cnt_en is registered one cycle after the prescaler terminal; stop suppresses strobes in its own cycle.
module counter_ctrl #(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    counter_ctrl_if.slave bus
);
    localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state;
    logic [PW-1:0]    presc;
    logic             dir_lat;
    logic [WIDTH-1:0] lim_lat;
    logic             en_q;

    logic [WIDTH-1:0] target;
    logic             at_target;
    logic             step;

    assign target    = dir_lat ? lim_lat : '0;
    assign at_target = (bus.cnt_val == target);
    // Terminal check wins over stepping, so the counter is never driven past target.
    assign step      = (state == S_RUN) && !bus.stop && !at_target && !bus.pause
                       && (presc == PW'(PRESCALE - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            presc   <= '0;
            dir_lat <= 1'b0;
            lim_lat <= '0;
            en_q    <= 1'b0;
        end else begin
            en_q <= step;
            case (state)
                S_IDLE: begin
                    if (bus.start && !bus.stop) begin
                        dir_lat <= bus.dir_sel;
                        lim_lat <= bus.limit;
                        state   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    presc <= '0;
                    state <= bus.stop ? S_IDLE : S_RUN;
                end
                S_RUN: begin
                    if (bus.stop) begin
                        state <= S_IDLE;
                    end else if (at_target) begin
                        state <= S_DONE;
                    end else if (!bus.pause) begin
                        presc <= step ? '0 : presc + PW'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.cnt_load     = (state == S_LOAD) && !bus.stop;
    assign bus.cnt_load_val = (state == S_LOAD) ? (dir_lat ? '0 : lim_lat) : '0;
    assign bus.cnt_en       = en_q && !bus.stop;
    assign bus.cnt_up       = dir_lat;
    assign bus.busy         = (state != S_IDLE);
    assign bus.done         = (state == S_DONE) && !bus.stop;
endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl with a behavioural up/down counter closing the feedback loop.
module tb_counter_ctrl;
    logic       clk;
    logic       rst_n;
    logic [3:0] cnt_model;
    int         checks;
    int         failures;

    counter_ctrl_if #(.WIDTH(4)) bus ();

    counter_ctrl #(.WIDTH(4), .PRESCALE(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    assign bus.cnt_val = cnt_model;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)              cnt_model <= 4'd0;
        else if (bus.cnt_load)   cnt_model <= bus.cnt_load_val;
        else if (bus.cnt_en)     cnt_model <= bus.cnt_up ? cnt_model + 4'd1 : cnt_model - 4'd1;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_run(input logic d, input logic [3:0] lim);
        bus.dir_sel = d;
        bus.limit   = lim;
        bus.start   = 1'b1;
        tick();
        bus.start   = 1'b0;
    endtask

    task automatic test_reset();
        logic [8:0] outs;
        int         dcnt;
        rst_n = 1'b0;
        tick(); tick();
        outs = {bus.busy, bus.cnt_load, bus.cnt_en, bus.done, bus.cnt_up, bus.cnt_load_val};
        checks++;
        if (outs !== 9'd0) begin failures++; $display("FAIL reset_outputs got=%b exp=%b", outs, 9'd0); end
        rst_n = 1'b1;
        tick();
        begin_run(1'b1, 4'd9);
        repeat (7) tick();
        #3;
        rst_n = 1'b0;
        #1;
        outs = {bus.busy, bus.cnt_load, bus.cnt_en, bus.done, bus.cnt_up, bus.cnt_load_val};
        checks++;
        if (outs !== 9'd0) begin failures++; $display("FAIL midrun_reset_outputs got=%b exp=%b", outs, 9'd0); end
        tick();
        rst_n = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus.done) dcnt++;
        end
        checks++;
        if (dcnt !== 0) begin failures++; $display("FAIL reset_no_done got=%0d exp=0", dcnt); end
        checks++;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_idle_busy got=%b exp=0", bus.busy); end
    endtask

    task automatic test_up_run();
        logic [63:0] en_mask, done_mask;
        logic [3:0]  v14;
        logic        b15, b16;
        en_mask = '0; done_mask = '0; v14 = '0; b15 = 1'b0; b16 = 1'b1;
        begin_run(1'b1, 4'd3);
        checks++;
        if (bus.cnt_load !== 1'b1) begin failures++; $display("FAIL up_load got=%b exp=1", bus.cnt_load); end
        checks++;
        if (bus.cnt_load_val !== 4'd0) begin failures++; $display("FAIL up_load_val got=%0d exp=0", bus.cnt_load_val); end
        checks++;
        if (bus.cnt_up !== 1'b1) begin failures++; $display("FAIL up_dir got=%b exp=1", bus.cnt_up); end
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (bus.cnt_en) en_mask[i] = 1'b1;
            if (bus.done)   done_mask[i] = 1'b1;
            if (i == 14) v14 = bus.cnt_val;
            if (i == 15) b15 = bus.busy;
            if (i == 16) b16 = bus.busy;
        end
        checks++;
        if (en_mask !== 64'h2220) begin failures++; $display("FAIL up_en_cycles got=%h exp=%h", en_mask, 64'h2220); end
        checks++;
        if (done_mask !== 64'h8000) begin failures++; $display("FAIL up_done_cycle got=%h exp=%h", done_mask, 64'h8000); end
        checks++;
        if (v14 !== 4'd3) begin failures++; $display("FAIL up_cnt_e14 got=%0d exp=3", v14); end
        checks++;
        if (b15 !== 1'b1 || b16 !== 1'b0) begin failures++; $display("FAIL up_busy_fall got=%b%b exp=10", b15, b16); end
    endtask

    task automatic test_down_run();
        logic [63:0] en_mask;
        int          dcnt, done_at;
        logic        up_seen;
        logic [3:0]  v22;
        en_mask = '0; dcnt = 0; done_at = -1; up_seen = 1'b0; v22 = 4'hf;
        begin_run(1'b0, 4'd5);
        checks++;
        if (bus.cnt_load_val !== 4'd5) begin failures++; $display("FAIL down_load_val got=%0d exp=5", bus.cnt_load_val); end
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (bus.cnt_en) en_mask[i] = 1'b1;
            if (bus.done) begin dcnt++; done_at = i; end
            if (bus.busy && bus.cnt_up !== 1'b0) up_seen = 1'b1;
            if (i == 22) v22 = bus.cnt_val;
        end
        checks++;
        if (en_mask !== 64'h222220) begin failures++; $display("FAIL down_en_cycles got=%h exp=%h", en_mask, 64'h222220); end
        checks++;
        if (up_seen !== 1'b0) begin failures++; $display("FAIL down_dir got=%b exp=0", up_seen); end
        checks++;
        if (v22 !== 4'd0) begin failures++; $display("FAIL down_cnt_final got=%0d exp=0", v22); end
        checks++;
        if (dcnt !== 1 || done_at !== 23) begin failures++; $display("FAIL down_done got=%0d@%0d exp=1@23", dcnt, done_at); end
    endtask

    task automatic test_pause();
        logic [63:0] en_mask;
        int          dcnt, done_at;
        en_mask = '0; dcnt = 0; done_at = -1;
        begin_run(1'b1, 4'd3);
        for (int i = 1; i <= 30; i++) begin
            tick();
            bus.pause = (i >= 6 && i <= 12);
            if (bus.cnt_en) en_mask[i] = 1'b1;
            if (bus.done) begin dcnt++; done_at = i; end
        end
        checks++;
        if (en_mask !== 64'h110020) begin failures++; $display("FAIL pause_en_cycles got=%h exp=%h", en_mask, 64'h110020); end
        checks++;
        if (dcnt !== 1 || done_at !== 22) begin failures++; $display("FAIL pause_done got=%0d@%0d exp=1@22", dcnt, done_at); end
    endtask

    task automatic test_abort();
        logic [63:0] en_mask;
        int          dcnt;
        logic        b11, seen;
        en_mask = '0; dcnt = 0; b11 = 1'b1; seen = 1'b0;
        begin_run(1'b1, 4'd5);
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (bus.cnt_en) en_mask[i] = 1'b1;
            if (bus.done) dcnt++;
            if (i == 11) b11 = bus.busy;
            bus.stop = (i == 10);
        end
        checks++;
        if (en_mask !== 64'h220) begin failures++; $display("FAIL abort_en_cycles got=%h exp=%h", en_mask, 64'h220); end
        checks++;
        if (dcnt !== 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", dcnt); end
        checks++;
        if (b11 !== 1'b0) begin failures++; $display("FAIL abort_idle got=%b exp=0", b11); end
        begin_run(1'b0, 4'd7);
        bus.stop = 1'b1;
        #1;
        checks++;
        if (bus.cnt_load !== 1'b0) begin failures++; $display("FAIL stop_in_load got=%b exp=0", bus.cnt_load); end
        tick();
        bus.stop = 1'b0;
        checks++;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL stop_load_idle got=%b exp=0", bus.busy); end
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.cnt_load || bus.busy) seen = 1'b1;
        end
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        checks++;
        if (seen !== 1'b0) begin failures++; $display("FAIL start_stop_idle got=%b exp=0", seen); end
    endtask

    task automatic test_limit_zero();
        logic [63:0] en_mask, done_mask;
        logic        b3;
        en_mask = '0; done_mask = '0; b3 = 1'b1;
        begin_run(1'b1, 4'd0);
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (bus.cnt_en) en_mask[i] = 1'b1;
            if (bus.done)   done_mask[i] = 1'b1;
            if (i == 3) b3 = bus.busy;
        end
        checks++;
        if (en_mask !== 64'h0) begin failures++; $display("FAIL zero_no_en got=%h exp=0", en_mask); end
        checks++;
        if (done_mask !== 64'h4) begin failures++; $display("FAIL zero_done_cycle got=%h exp=%h", done_mask, 64'h4); end
        checks++;
        if (b3 !== 1'b0) begin failures++; $display("FAIL zero_busy_fall got=%b exp=0", b3); end
    endtask

    task automatic test_midrun_change();
        int         n_en, done_at;
        logic       up_low;
        logic [3:0] v62;
        n_en = 0; done_at = -1; up_low = 1'b0; v62 = '0;
        begin_run(1'b1, 4'd15);
        for (int i = 1; i <= 70; i++) begin
            tick();
            if (i == 10) begin bus.limit = 4'd2; bus.dir_sel = 1'b0; end
            if (bus.cnt_en) n_en++;
            if (bus.done) done_at = i;
            if (bus.busy && bus.cnt_up !== 1'b1) up_low = 1'b1;
            if (i == 62) v62 = bus.cnt_val;
        end
        checks++;
        if (n_en !== 15) begin failures++; $display("FAIL latch_en_count got=%0d exp=15", n_en); end
        checks++;
        if (up_low !== 1'b0) begin failures++; $display("FAIL latch_dir got=%b exp=0", up_low); end
        checks++;
        if (v62 !== 4'd15) begin failures++; $display("FAIL latch_cnt_final got=%0d exp=15", v62); end
        checks++;
        if (done_at !== 63) begin failures++; $display("FAIL latch_done_cycle got=%0d exp=63", done_at); end
    endtask

    task automatic test_back_to_back();
        logic b3, l4;
        int   dcnt;
        b3 = 1'b1; l4 = 1'b0; dcnt = 0;
        bus.dir_sel = 1'b1;
        bus.limit   = 4'd0;
        bus.start   = 1'b1;
        tick();
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (bus.done) dcnt++;
            if (i == 3) b3 = bus.busy;
            if (i == 4) begin l4 = bus.cnt_load; bus.start = 1'b0; end
        end
        checks++;
        if (b3 !== 1'b0) begin failures++; $display("FAIL b2b_idle_gap got=%b exp=0", b3); end
        checks++;
        if (l4 !== 1'b1) begin failures++; $display("FAIL b2b_reload got=%b exp=1", l4); end
        checks++;
        if (dcnt !== 2) begin failures++; $display("FAIL b2b_done_count got=%0d exp=2", dcnt); end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.stop    = 1'b0;
        bus.pause   = 1'b0;
        bus.dir_sel = 1'b0;
        bus.limit   = 4'd0;
        test_reset();
        test_up_run();
        test_down_run();
        test_pause();
        test_abort();
        test_limit_zero();
        test_midrun_change();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
